// File: rtl/exc_collector_pkg.sv
// Shared definitions for the MEM-stage exception collector: excepttype layout,
// CP0 exception codes, load/store op encodings and redirect FSM states.
package exc_collector_pkg;

  localparam int EXCEPTTYPE_WD = 16;
  localparam int PC_WD         = 32;

  // Bit positions inside the CP0 excepttype bus
  localparam int ET_MTC0    = 0;
  localparam int ET_MFC0    = 1;
  localparam int ET_ERET    = 2;
  localparam int ET_RI      = 3;
  localparam int ET_BREAK   = 4;
  localparam int ET_SYSCALL = 5;
  localparam int ET_OV      = 6;
  localparam int ET_ADEL    = 7;
  localparam int ET_ADES    = 8;
  localparam int ET_PC_ADDR = 9;
  localparam int ET_DSLOT   = 10;
  localparam int ET_ADDR_LO = 11;
  localparam int ET_ADDR_HI = 15;

  // MIPS Cause.ExcCode values
  localparam logic [4:0] EXC_CODE_INT  = 5'h00;
  localparam logic [4:0] EXC_CODE_ADEL = 5'h04;
  localparam logic [4:0] EXC_CODE_ADES = 5'h05;
  localparam logic [4:0] EXC_CODE_SYS  = 5'h08;
  localparam logic [4:0] EXC_CODE_BP   = 5'h09;
  localparam logic [4:0] EXC_CODE_RI   = 5'h0a;
  localparam logic [4:0] EXC_CODE_OV   = 5'h0c;

  typedef enum logic [2:0] {
    LS_NONE = 3'b000,
    LS_LW   = 3'b001,
    LS_LH   = 3'b010,
    LS_LB   = 3'b011,
    LS_SW   = 3'b101,
    LS_SH   = 3'b110,
    LS_SB   = 3'b111
  } ls_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_addr;
    logic ri;
    logic syscall;
    logic brk;
    logic ov;
    logic adel;
    logic ades;
  } exc_flags_t;

  // Keep only the highest-priority raised exception.
  function automatic exc_flags_t prioritise(input exc_flags_t raw);
    exc_flags_t win;
    win = '0;
    if (raw.pc_addr)      win.pc_addr = 1'b1;
    else if (raw.ri)      win.ri      = 1'b1;
    else if (raw.syscall) win.syscall = 1'b1;
    else if (raw.brk)     win.brk     = 1'b1;
    else if (raw.ov)      win.ov      = 1'b1;
    else if (raw.adel)    win.adel    = 1'b1;
    else if (raw.ades)    win.ades    = 1'b1;
    return win;
  endfunction

  function automatic logic [4:0] exc_code_of(input exc_flags_t win);
    logic [4:0] code;
    code = EXC_CODE_INT;
    if (win.pc_addr || win.adel) code = EXC_CODE_ADEL;
    else if (win.ri)             code = EXC_CODE_RI;
    else if (win.syscall)        code = EXC_CODE_SYS;
    else if (win.brk)            code = EXC_CODE_BP;
    else if (win.ov)             code = EXC_CODE_OV;
    else if (win.ades)           code = EXC_CODE_ADES;
    return code;
  endfunction

endpackage

// File: rtl/exc_collector_if.sv
// MEM-stage / CP0 / IF-redirect signal bundle for the exception collector.
interface exc_collector_if;
  import exc_collector_pkg::*;

  logic                     mem_valid;
  logic                     mem_stall;
  logic [PC_WD-1:0]         mem_pc;
  logic                     mem_in_dslot;
  logic [4:0]               mem_exc_in;
  logic [2:0]               mem_cp0_op;
  logic [4:0]               mem_cp0_addr;
  logic [PC_WD-1:0]         mem_rt_rdata;
  logic [2:0]               mem_ls_op;
  logic [PC_WD-1:0]         mem_addr;
  logic                     cp0_flush;
  logic [PC_WD-1:0]         cp0_new_pc;
  logic                     redirect_ready;
  logic [EXCEPTTYPE_WD-1:0] excepttype;
  logic [PC_WD-1:0]         cur_pc;
  logic [PC_WD-1:0]         bad_addr;
  logic [PC_WD-1:0]         rt_rdata;
  logic                     dmem_kill;
  logic                     flush_o;
  logic                     redirect_valid;
  logic [PC_WD-1:0]         redirect_pc;

  modport master (
    output mem_valid, mem_stall, mem_pc, mem_in_dslot, mem_exc_in,
           mem_cp0_op, mem_cp0_addr, mem_rt_rdata, mem_ls_op, mem_addr,
           cp0_flush, cp0_new_pc, redirect_ready,
    input  excepttype, cur_pc, bad_addr, rt_rdata, dmem_kill,
           flush_o, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_valid, mem_stall, mem_pc, mem_in_dslot, mem_exc_in,
           mem_cp0_op, mem_cp0_addr, mem_rt_rdata, mem_ls_op, mem_addr,
           cp0_flush, cp0_new_pc, redirect_ready,
    output excepttype, cur_pc, bad_addr, rt_rdata, dmem_kill,
           flush_o, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/exc_collector_align_check.sv
// Data-address alignment check for MEM-stage loads and stores.
module exc_collector_align_check
  import exc_collector_pkg::*;
(
  input  logic [2:0] ls_op,
  input  logic [1:0] addr_lo,
  output logic       adel,
  output logic       ades
);

  // Byte accesses and non-memory ops never fault.
  always_comb begin
    adel = 1'b0;
    ades = 1'b0;
    case (ls_op)
      LS_LW:   adel = (addr_lo != 2'b00);
      LS_LH:   adel = addr_lo[0];
      LS_SW:   ades = (addr_lo != 2'b00);
      LS_SH:   ades = addr_lo[0];
      default: ;
    endcase
  end

endmodule

// File: rtl/exc_collector.sv
// MEM-stage exception collector: prioritises exceptions into the CP0 excepttype
// bus and turns a CP0 flush request into a pipeline flush plus a held IF redirect.
module exc_collector
  import exc_collector_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  exc_collector_if.slave bus
);

  state_e                   state;
  logic                     adel;
  logic                     ades;
  exc_flags_t               raw_exc;
  exc_flags_t               win_exc;
  logic                     any_exc;
  logic [EXCEPTTYPE_WD-1:0] next_excepttype;
  logic [PC_WD-1:0]         next_bad_addr;

  exc_collector_align_check u_align_check (
    .ls_op   (bus.mem_ls_op),
    .addr_lo (bus.mem_addr[1:0]),
    .adel    (adel),
    .ades    (ades)
  );

  // An empty slot raises nothing; CP0 op bits only survive when nothing faulted.
  always_comb begin
    raw_exc         = '0;
    next_excepttype = '0;
    next_bad_addr   = '0;
    if (bus.mem_valid) begin
      raw_exc.pc_addr = bus.mem_exc_in[4];
      raw_exc.ri      = bus.mem_exc_in[3];
      raw_exc.syscall = bus.mem_exc_in[2];
      raw_exc.brk     = bus.mem_exc_in[1];
      raw_exc.ov      = bus.mem_exc_in[0];
      raw_exc.adel    = adel;
      raw_exc.ades    = ades;
    end
    win_exc = prioritise(raw_exc);
    any_exc = |raw_exc;

    if (bus.mem_valid) begin
      next_excepttype[ET_ADDR_HI:ET_ADDR_LO] = bus.mem_cp0_addr;
      next_excepttype[ET_DSLOT]              = bus.mem_in_dslot;
      next_excepttype[ET_PC_ADDR]            = win_exc.pc_addr;
      next_excepttype[ET_ADES]               = win_exc.ades;
      next_excepttype[ET_ADEL]               = win_exc.adel;
      next_excepttype[ET_OV]                 = win_exc.ov;
      next_excepttype[ET_SYSCALL]            = win_exc.syscall;
      next_excepttype[ET_BREAK]              = win_exc.brk;
      next_excepttype[ET_RI]                 = win_exc.ri;
      if (!any_exc) begin
        next_excepttype[ET_ERET:ET_MTC0] = bus.mem_cp0_op;
      end
    end

    if (win_exc.pc_addr) begin
      next_bad_addr = bus.mem_pc;
    end else if (win_exc.adel || win_exc.ades) begin
      next_bad_addr = bus.mem_addr;
    end
  end

  assign bus.dmem_kill = any_exc || (state != ST_IDLE);

  // A flush request takes precedence over a stall and freezes capture until IF
  // accepts the redirect; ready is only looked at from the first REDIR cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      bus.excepttype     <= '0;
      bus.cur_pc         <= '0;
      bus.bad_addr       <= '0;
      bus.rt_rdata       <= '0;
      bus.flush_o        <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.flush_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cp0_flush) begin
            state              <= ST_REDIR;
            bus.flush_o        <= 1'b1;
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= bus.cp0_new_pc;
            bus.excepttype     <= '0;
          end else if (!bus.mem_stall) begin
            bus.excepttype <= next_excepttype;
            bus.cur_pc     <= bus.mem_pc;
            bus.bad_addr   <= next_bad_addr;
            bus.rt_rdata   <= bus.mem_rt_rdata;
          end
        end
        ST_REDIR: begin
          if (bus.redirect_ready) begin
            state              <= ST_IDLE;
            bus.redirect_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_collector.sv
// Bench for exc_collector: directed vector table, multi-cycle corner sequences,
// then random traffic checked against a rule-level reference model.
module tb_exc_collector;
  import exc_collector_pkg::*;

  typedef struct {
    logic        valid;
    logic        stall;
    logic [31:0] pc;
    logic        dslot;
    logic [4:0]  exc_in;
    logic [2:0]  cp0_op;
    logic [4:0]  cp0_addr;
    logic [31:0] rt;
    logic [2:0]  ls_op;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] new_pc;
    logic        ready;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [15:0] et;
    logic [31:0] bad;
    logic        bad_chk;
    logic        kill;
  } vec_t;

  logic clk;
  logic rst;
  exc_collector_if bus();

  exc_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared;
  int n_mismatched;

  logic        m_redir;
  logic [15:0] m_et;
  logic [31:0] m_cur;
  logic [31:0] m_bad;
  logic        m_bad_known;
  logic [31:0] m_rt;
  logic        m_flush;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic        m_rpc_known;

  vec_t vecs[10];

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic stim_t mkStim(input logic valid, input logic [31:0] pc, input logic dslot,
                                   input logic [4:0] exc_in, input logic [2:0] cp0_op,
                                   input logic [4:0] cp0_addr, input logic [31:0] rt,
                                   input logic [2:0] ls_op, input logic [31:0] addr);
    stim_t s;
    s.valid = valid;   s.stall = 1'b0;  s.pc = pc;         s.dslot = dslot;
    s.exc_in = exc_in; s.cp0_op = cp0_op; s.cp0_addr = cp0_addr; s.rt = rt;
    s.ls_op = ls_op;   s.addr = addr;   s.flush = 1'b0;    s.new_pc = 32'h0;
    s.ready = 1'b0;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input logic [15:0] et, input logic [31:0] bad,
                                 input logic bad_chk, input logic kill);
    vec_t v;
    v.s = s; v.et = et; v.bad = bad; v.bad_chk = bad_chk; v.kill = kill;
    return v;
  endfunction

  // Reference: access size decides alignment; the first raised flag in priority order wins.
  function automatic void expectedCapture(input stim_t s, output logic [15:0] et, output logic [31:0] bad,
                                          output logic bad_known, output logic has_exc);
    logic [31:0] size;
    logic        misaligned, is_load, is_store;
    logic        flags[7];
    int          pos[7];
    int          winner;
    pos = '{9, 3, 5, 4, 6, 7, 8};
    case (s.ls_op)
      3'b001, 3'b101: size = 32'd4;
      3'b010, 3'b110: size = 32'd2;
      default:        size = 32'd1;
    endcase
    misaligned = (s.addr % size) != 32'd0;
    is_load    = s.ls_op inside {3'b001, 3'b010, 3'b011};
    is_store   = s.ls_op inside {3'b101, 3'b110, 3'b111};
    flags = '{s.exc_in[4], s.exc_in[3], s.exc_in[2], s.exc_in[1], s.exc_in[0],
              is_load && misaligned, is_store && misaligned};
    winner = -1;
    if (s.valid) begin
      for (int k = 6; k >= 0; k--) begin
        if (flags[k]) winner = k;
      end
    end
    et = 16'h0; bad = 32'h0; bad_known = 1'b0;
    has_exc = (winner >= 0);
    if (s.valid) begin
      et[15:11] = s.cp0_addr;
      et[10]    = s.dslot;
      if (winner >= 0) et[pos[winner]] = 1'b1;
      else             et[2:0]         = s.cp0_op;
      if (winner == 0) begin
        bad = s.pc; bad_known = 1'b1;
      end else if (winner == 5 || winner == 6) begin
        bad = s.addr; bad_known = 1'b1;
      end
    end
  endfunction

  task automatic modelReset();
    m_redir = 1'b0; m_et = 16'h0; m_cur = 32'h0; m_bad = 32'h0; m_bad_known = 1'b1;
    m_rt = 32'h0; m_flush = 1'b0; m_rv = 1'b0; m_rpc = 32'h0; m_rpc_known = 1'b1;
  endtask

  task automatic modelAdvance(input stim_t s);
    logic [15:0] et;
    logic [31:0] bad;
    logic        bk, hx;
    if (rst) begin
      modelReset();
    end else begin
      m_flush = 1'b0;
      if (m_redir) begin
        if (s.ready) begin
          m_redir = 1'b0; m_rv = 1'b0; m_rpc_known = 1'b0;
        end
      end else if (s.flush) begin
        m_redir = 1'b1; m_rv = 1'b1; m_flush = 1'b1; m_rpc = s.new_pc; m_rpc_known = 1'b1;
        m_et = 16'h0;
      end else if (!s.stall) begin
        expectedCapture(s, et, bad, bk, hx);
        m_et = et; m_cur = s.pc; m_rt = s.rt; m_bad = bad; m_bad_known = bk;
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bus.mem_valid      = s.valid;
    bus.mem_stall      = s.stall;
    bus.mem_pc         = s.pc;
    bus.mem_in_dslot   = s.dslot;
    bus.mem_exc_in     = s.exc_in;
    bus.mem_cp0_op     = s.cp0_op;
    bus.mem_cp0_addr   = s.cp0_addr;
    bus.mem_rt_rdata   = s.rt;
    bus.mem_ls_op      = s.ls_op;
    bus.mem_addr       = s.addr;
    bus.cp0_flush      = s.flush;
    bus.cp0_new_pc     = s.new_pc;
    bus.redirect_ready = s.ready;
  endtask

  task automatic checkOutput();
    compare("excepttype", 32'(bus.excepttype), 32'(m_et));
    compare("cur_pc", bus.cur_pc, m_cur);
    compare("rt_rdata", bus.rt_rdata, m_rt);
    if (m_bad_known) compare("bad_addr", bus.bad_addr, m_bad);
    compare("flush_o", 32'(bus.flush_o), 32'(m_flush));
    compare("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    if (m_rpc_known) compare("redirect_pc", bus.redirect_pc, m_rpc);
  endtask

  task automatic clockStep(input stim_t s);
    logic [15:0] et;
    logic [31:0] bad;
    logic        bk, hx;
    applyStimulus(s);
    #1;
    expectedCapture(s, et, bad, bk, hx);
    compare("dmem_kill", 32'(bus.dmem_kill), 32'(m_redir | hx));
    modelAdvance(s);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic stim_t randomStim();
    stim_t s;
    s.valid    = ($urandom_range(0, 3) != 0);
    s.stall    = ($urandom_range(0, 3) == 0);
    s.pc       = $urandom;
    s.dslot    = 1'($urandom_range(0, 1));
    s.exc_in   = 5'h0;
    for (int b = 0; b < 5; b++) begin
      if ($urandom_range(0, 7) == 0) s.exc_in[b] = 1'b1;
    end
    s.cp0_op   = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
    s.cp0_addr = 5'($urandom_range(0, 31));
    s.rt       = $urandom;
    s.ls_op    = 3'($urandom_range(0, 7));
    s.addr     = $urandom;
    s.flush    = ($urandom_range(0, 9) == 0);
    s.new_pc   = $urandom;
    s.ready    = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  initial begin
    stim_t idle;
    stim_t s;
    int    flushes;
    n_compared   = 0;
    n_mismatched = 0;
    idle = mkStim(1'b0, 32'h0, 1'b0, 5'h0, 3'h0, 5'h0, 32'h0, 3'b000, 32'h0);

    rst = 1'b1;
    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    compare("reset excepttype", 32'(bus.excepttype), 32'h0);
    compare("reset cur_pc", bus.cur_pc, 32'h0);
    compare("reset bad_addr", bus.bad_addr, 32'h0);
    compare("reset rt_rdata", bus.rt_rdata, 32'h0);
    compare("reset dmem_kill", 32'(bus.dmem_kill), 32'h0);
    compare("reset flush_o", 32'(bus.flush_o), 32'h0);
    compare("reset redirect_valid", 32'(bus.redirect_valid), 32'h0);
    compare("reset redirect_pc", bus.redirect_pc, 32'h0);
    rst = 1'b0;

    vecs[0] = mkVec(mkStim(1, 32'hbfc00100, 0, 5'b00000, 3'b000, 5'd0,  32'h11, 3'b001, 32'h00001002), 16'h0080, 32'h00001002, 1, 1);
    vecs[1] = mkVec(mkStim(1, 32'hbfc00200, 0, 5'b00101, 3'b000, 5'd0,  32'h22, 3'b000, 32'h00000000), 16'h0020, 32'h0, 0, 1);
    vecs[2] = mkVec(mkStim(1, 32'hbfc00301, 0, 5'b11000, 3'b000, 5'd0,  32'h33, 3'b000, 32'h00000000), 16'h0200, 32'hbfc00301, 1, 1);
    vecs[3] = mkVec(mkStim(1, 32'hbfc00400, 1, 5'b00000, 3'b001, 5'd12, 32'h44, 3'b111, 32'h00000003), 16'h6401, 32'h0, 0, 0);
    vecs[4] = mkVec(mkStim(1, 32'hbfc00500, 0, 5'b00000, 3'b000, 5'd0,  32'h55, 3'b110, 32'h00002001), 16'h0100, 32'h00002001, 1, 1);
    vecs[5] = mkVec(mkStim(1, 32'hbfc00600, 0, 5'b00000, 3'b010, 5'd14, 32'h66, 3'b010, 32'h00002002), 16'h7002, 32'h0, 0, 0);
    vecs[6] = mkVec(mkStim(1, 32'hbfc00700, 0, 5'b00000, 3'b100, 5'd0,  32'h77, 3'b101, 32'h00003003), 16'h0100, 32'h00003003, 1, 1);
    vecs[7] = mkVec(mkStim(0, 32'hbfc00800, 1, 5'b11111, 3'b111, 5'd9,  32'h88, 3'b001, 32'h00000001), 16'h0000, 32'h0, 0, 0);
    vecs[8] = mkVec(mkStim(1, 32'hbfc00900, 0, 5'b01000, 3'b000, 5'd0,  32'h99, 3'b101, 32'h00000002), 16'h0008, 32'h0, 0, 1);
    vecs[9] = mkVec(mkStim(1, 32'hbfc00a00, 0, 5'b00001, 3'b000, 5'd0,  32'haa, 3'b011, 32'h00000007), 16'h0040, 32'h0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      clockStep(vecs[i].s);
      compare($sformatf("vec%0d excepttype", i), 32'(bus.excepttype), 32'(vecs[i].et));
      compare($sformatf("vec%0d dmem_kill", i), 32'(bus.dmem_kill), 32'(vecs[i].kill));
      if (vecs[i].s.valid) compare($sformatf("vec%0d cur_pc", i), bus.cur_pc, vecs[i].s.pc);
      if (vecs[i].bad_chk) compare($sformatf("vec%0d bad_addr", i), bus.bad_addr, vecs[i].bad);
    end

    // Flush during a stall with ready already high; later flush requests are ignored.
    s = mkStim(1, 32'hbfc00b00, 0, 5'b00100, 3'b000, 5'd0, 32'hbb, 3'b000, 32'h0);
    s.stall = 1'b1; s.flush = 1'b1; s.new_pc = 32'hbfc00380; s.ready = 1'b1;
    clockStep(s);
    flushes = int'(bus.flush_o);
    compare("flush entry flush_o", 32'(bus.flush_o), 32'h1);
    compare("flush entry redirect_valid", 32'(bus.redirect_valid), 32'h1);
    compare("flush entry redirect_pc", bus.redirect_pc, 32'hbfc00380);
    compare("flush entry excepttype", 32'(bus.excepttype), 32'h0);
    for (int i = 0; i < 3; i++) begin
      s = mkStim(1, 32'hbfc00c00, 0, 5'b00010, 3'b000, 5'd0, 32'hcc, 3'b001, 32'h1);
      if (i == 1) begin
        s.flush = 1'b1; s.new_pc = 32'h12345678;
      end
      clockStep(s);
      flushes += int'(bus.flush_o);
      compare("redir hold redirect_valid", 32'(bus.redirect_valid), 32'h1);
      compare("redir hold redirect_pc", bus.redirect_pc, 32'hbfc00380);
      compare("redir hold excepttype", 32'(bus.excepttype), 32'h0);
    end
    s = idle;
    s.ready = 1'b1;
    clockStep(s);
    flushes += int'(bus.flush_o);
    compare("redir accept redirect_valid", 32'(bus.redirect_valid), 32'h0);
    compare("flush_o pulse count", 32'(flushes), 32'h1);
    clockStep(idle);
    compare("post redir dmem_kill", 32'(bus.dmem_kill), 32'h0);

    // Stall holds captured state while new exception inputs arrive.
    clockStep(mkStim(1, 32'h80000010, 0, 5'b00000, 3'b000, 5'd0, 32'hd0, 3'b001, 32'h20000002));
    s = mkStim(1, 32'h80000020, 0, 5'b00100, 3'b000, 5'd0, 32'hd1, 3'b000, 32'h0);
    s.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clockStep(s);
      compare("stall excepttype", 32'(bus.excepttype), 32'h0080);
      compare("stall cur_pc", bus.cur_pc, 32'h80000010);
      compare("stall bad_addr", bus.bad_addr, 32'h20000002);
    end
    s.stall = 1'b0;
    clockStep(s);
    compare("release excepttype", 32'(bus.excepttype), 32'h0020);
    compare("release cur_pc", bus.cur_pc, 32'h80000020);

    // Reset while a redirect is pending.
    s = idle;
    s.flush = 1'b1; s.new_pc = 32'hbfc00380;
    clockStep(s);
    rst = 1'b1;
    clockStep(idle);
    rst = 1'b0;
    compare("rst redir redirect_valid", 32'(bus.redirect_valid), 32'h0);
    compare("rst redir redirect_pc", bus.redirect_pc, 32'h0);
    compare("rst redir flush_o", 32'(bus.flush_o), 32'h0);
    compare("rst redir excepttype", 32'(bus.excepttype), 32'h0);
    compare("rst redir cur_pc", bus.cur_pc, 32'h0);
    compare("rst redir dmem_kill", 32'(bus.dmem_kill), 32'h0);
    clockStep(idle);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      clockStep(randomStim());
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
